unidad_riesgos_param: RTL and testbench

Parametrised hazard unit for the filter-processor pipeline, with decode (Reg), Exe, Mem and WB stages. It keeps its own shadow pipeline of destination tags for the instructions in Exe, Mem and later stages. For each issuing instruction it computes per-operand forwarding selects, registered so they align with that instruction's Exe cycle. It also detects load-use hazards and requests stall cycles, inserting bubbles into the tag pipeline. Store-data forwarding is handled by making the store-data register one of the NUM_SRC operands, so no separate memory-risk selects exist.

---
 rtl/unidad_riesgos_param.sv | 120 ++++++++++++
 tb/tb_unidad_riesgos_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_riesgos_param.sv
// Hazard unit: shadow tag pipeline, per-operand forwarding selects and load-use stall.
// Optional RIESGOS_STATS_EN adds saturating stall_count / fwd_count outputs.
module unidad_riesgos_param #(
    parameter int REG_W     = 4,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [NUM_SRC*REG_W-1:0] issue_src,
    input  logic [NUM_SRC-1:0]       issue_re,
    input  logic [REG_W-1:0]         issue_dst,
    input  logic                     issue_we,
    input  logic                     issue_is_load,
    input  logic                     pipe_hold,
    input  logic                     flush,
    output logic                     stall,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel
`ifdef RIESGOS_STATS_EN
    ,
    output logic [15:0]              stall_count,
    output logic [15:0]              fwd_count
`endif
);

    logic [FWD_DEPTH-1:0] t_valid;
    logic [FWD_DEPTH-1:0] t_we;
    logic [FWD_DEPTH-1:0] t_ld;
    logic [REG_W-1:0]     t_dst [FWD_DEPTH];

    logic [NUM_SRC*SEL_W-1:0] sel_next;
    logic [SEL_W-1:0]         sel_k;
    logic                     hit_ld;
    logic                     stall_req;
    logic                     advance;
    logic                     bubble;

    // Scan oldest to youngest so the lowest matching entry overrides the rest.
    always_comb begin
        sel_next  = '0;
        sel_k     = '0;
        hit_ld    = 1'b0;
        stall_req = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sel_k  = '0;
            hit_ld = 1'b0;
            for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
                if (issue_valid && issue_re[k] && t_valid[j] && t_we[j] &&
                    (t_dst[j] == issue_src[k*REG_W +: REG_W])) begin
                    sel_k  = SEL_W'(j + 1);
                    hit_ld = t_ld[j] && (j < LOAD_LAT);
                end
            end
            sel_next[k*SEL_W +: SEL_W] = sel_k;
            stall_req = stall_req | hit_ld;
        end
    end

    assign stall   = stall_req;
    assign advance = flush || !pipe_hold;
    assign bubble  = flush || stall_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            t_valid <= '0;
            t_we    <= '0;
            t_ld    <= '0;
            fwd_sel <= '0;
            for (int j = 0; j < FWD_DEPTH; j++) begin
                t_dst[j] <= '0;
            end
        end else if (advance) begin
            for (int j = FWD_DEPTH - 1; j >= 1; j--) begin
                t_valid[j] <= t_valid[j-1];
                t_we[j]    <= t_we[j-1];
                t_ld[j]    <= t_ld[j-1];
                t_dst[j]   <= t_dst[j-1];
            end
            if (bubble) begin
                t_valid[0] <= 1'b0;
                t_we[0]    <= 1'b0;
                t_ld[0]    <= 1'b0;
                t_dst[0]   <= '0;
                fwd_sel    <= '0;
            end else begin
                t_valid[0] <= issue_valid;
                t_we[0]    <= issue_we;
                t_ld[0]    <= issue_is_load;
                t_dst[0]   <= issue_dst;
                fwd_sel    <= sel_next;
            end
        end
    end

`ifdef RIESGOS_STATS_EN
    logic stall_evt;
    logic fwd_evt;

    assign stall_evt = stall_req && !pipe_hold && !flush;
    assign fwd_evt   = !flush && !pipe_hold && !stall_req && (|sel_next);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            if (stall_evt && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (fwd_evt && (fwd_count != 16'hFFFF)) begin
                fwd_count <= fwd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_unidad_riesgos_param.sv
// Directed bench for unidad_riesgos_param (default parameters).
// Stats checks are compiled in only when RIESGOS_STATS_EN is defined.
module tb_unidad_riesgos_param;

    logic       clk;
    logic       reset;
    logic       issue_valid;
    logic [7:0] issue_src;
    logic [1:0] issue_re;
    logic [3:0] issue_dst;
    logic       issue_we;
    logic       issue_is_load;
    logic       pipe_hold;
    logic       flush;
    logic       stall;
    logic [3:0] fwd_sel;
`ifdef RIESGOS_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] fwd_count;
    logic [15:0] sc_snap;
`endif

    int total = 0;
    int bad   = 0;

    unidad_riesgos_param dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_src    (issue_src),
        .issue_re     (issue_re),
        .issue_dst    (issue_dst),
        .issue_we     (issue_we),
        .issue_is_load(issue_is_load),
        .pipe_hold    (pipe_hold),
        .flush        (flush),
        .stall        (stall),
        .fwd_sel      (fwd_sel)
`ifdef RIESGOS_STATS_EN
        ,
        .stall_count  (stall_count),
        .fwd_count    (fwd_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; registered outputs are sampled 1 after rising.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic [1:0] re,
                         input logic [3:0] d, input logic we,
                         input logic ld);
        @(negedge clk);
        issue_valid   = v;
        issue_src     = {b, a};
        issue_re      = re;
        issue_dst     = d;
        issue_we      = we;
        issue_is_load = ld;
        #1;
    endtask

    task automatic nop();
        issue(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop(); tick();
        nop(); tick();
    endtask

    initial begin
        reset = 1'b1;
        pipe_hold = 1'b0;
        flush = 1'b0;
        issue_valid = 1'b0;
        issue_src = '0;
        issue_re = '0;
        issue_dst = '0;
        issue_we = 1'b0;
        issue_is_load = 1'b0;
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_sel", fwd_sel, 4'd0);
        check("reset_stall", stall, 1'b0);
`ifdef RIESGOS_STATS_EN
        check("reset_scnt", stall_count, 16'd0);
`endif

        // ADD R1 ; SUB reads R1 on A
        issue(1'b1, 4'd0, 4'd0, 2'b00, 4'd1, 1'b1, 1'b0); tick();
        issue(1'b1, 4'd1, 4'd5, 2'b11, 4'd6, 1'b1, 1'b0);
        check("b2b_stall", stall, 1'b0);
        tick();
        check("b2b_sel", fwd_sel, 4'b0001);
        drain();

        // ADD R3 ; NOP ; ST with data operand B = R3
        issue(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0); tick();
        nop(); tick();
        issue(1'b1, 4'd7, 4'd3, 2'b11, 4'd0, 1'b0, 1'b0);
        check("gap_stall", stall, 1'b0);
        tick();
        check("gap_sel", fwd_sel, 4'b1000);
        drain();

        // Two producers of R2: youngest wins
        issue(1'b1, 4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b0); tick();
        issue(1'b1, 4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b0); tick();
        issue(1'b1, 4'd2, 4'd0, 2'b01, 4'd9, 1'b0, 1'b0); tick();
        check("prio_sel", fwd_sel, 4'b0001);
        drain();

        // Load-use: one stall, bubble, then select 2
        issue(1'b1, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 1'b1); tick();
        issue(1'b1, 4'd4, 4'd0, 2'b01, 4'd9, 1'b0, 1'b0);
        check("lu_stall1", stall, 1'b1);
        tick();
        check("lu_bubble", fwd_sel, 4'd0);
        check("lu_stall2", stall, 1'b0);
        tick();
        check("lu_sel", fwd_sel, 4'b0010);
        drain();

        // Hold with select 1; tag pipeline frozen
        issue(1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b0); tick();
        issue(1'b1, 4'd5, 4'd0, 2'b01, 4'd6, 1'b1, 1'b0); tick();
        check("hold_pre", fwd_sel, 4'b0001);
        nop();
        pipe_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_sel", fwd_sel, 4'b0001);
        end
        issue(1'b1, 4'd5, 4'd6, 2'b11, 4'd9, 1'b0, 1'b0);
        pipe_hold = 1'b0;
        #1;
        check("hold_rel_stall", stall, 1'b0);
        tick();
        check("hold_tags", fwd_sel, 4'b0110);
        drain();

        // Load-use under hold: stall driven but not counted
        issue(1'b1, 4'd0, 4'd0, 2'b00, 4'd8, 1'b1, 1'b1); tick();
        issue(1'b1, 4'd8, 4'd0, 2'b01, 4'd9, 1'b0, 1'b0);
        pipe_hold = 1'b1;
        #1;
        check("hld_ld_stall", stall, 1'b1);
`ifdef RIESGOS_STATS_EN
        sc_snap = stall_count;
`endif
        tick();
        tick();
        @(negedge clk);
        pipe_hold = 1'b0;
        #1;
        check("hld_ld_still", stall, 1'b1);
`ifdef RIESGOS_STATS_EN
        check("hld_scnt", stall_count, sc_snap);
`endif
        tick();
        check("hld_ld_bub", fwd_sel, 4'd0);
        check("hld_ld_go", stall, 1'b0);
`ifdef RIESGOS_STATS_EN
        check("hld_scnt_inc", stall_count, sc_snap + 16'd1);
`endif
        tick();
        check("hld_ld_sel", fwd_sel, 4'b0010);
        drain();

        // Reset in the middle of a load-use stall
        issue(1'b1, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 1'b1); tick();
        issue(1'b1, 4'd4, 4'd0, 2'b01, 4'd9, 1'b0, 1'b0);
        check("rst_pre_stall", stall, 1'b1);
        reset = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_sel", fwd_sel, 4'd0);
        tick();
        check("rst_after", fwd_sel, 4'd0);
        drain();

        // Flush on the load's issue cycle
        issue(1'b1, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 1'b1);
        flush = 1'b1;
        tick();
        issue(1'b1, 4'd4, 4'd0, 2'b01, 4'd9, 1'b0, 1'b0);
        flush = 1'b0;
        #1;
        check("fl_stall", stall, 1'b0);
        tick();
        check("fl_sel", fwd_sel, 4'd0);
        drain();

        // Idle issue never stalls
        issue(1'b1, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 1'b1); tick();
        issue(1'b0, 4'd4, 4'd4, 2'b11, 4'd9, 1'b0, 1'b0);
        check("idle_stall", stall, 1'b0);
        tick();
        check("idle_sel", fwd_sel, 4'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
